// File: rtl/ex_mem_flag_reg_pkg.sv
// ---------------------------------------------------------------------------
// ex_mem_flag_reg_pkg
//   Shared CPU definitions for the EX->MEM boundary: opcode encodings,
//   {Z,V,N} flag bit positions and the halt-sequencing FSM encoding.
//   Also used by the branch unit, so the encodings here are architectural.
// ---------------------------------------------------------------------------
package ex_mem_flag_reg_pkg;

    // Opcode encodings
    localparam logic [3:0] OP_ADD    = 4'h0;
    localparam logic [3:0] OP_SUB    = 4'h1;
    localparam logic [3:0] OP_XOR    = 4'h2;
    localparam logic [3:0] OP_RED    = 4'h3;
    localparam logic [3:0] OP_SLL    = 4'h4;
    localparam logic [3:0] OP_SRA    = 4'h5;
    localparam logic [3:0] OP_ROR    = 4'h6;
    localparam logic [3:0] OP_PADDSB = 4'h7;
    localparam logic [3:0] OP_LW     = 4'h8;
    localparam logic [3:0] OP_SW     = 4'h9;
    localparam logic [3:0] OP_LHB    = 4'hA;
    localparam logic [3:0] OP_LLB    = 4'hB;
    localparam logic [3:0] OP_B      = 4'hC;
    localparam logic [3:0] OP_BR     = 4'hD;
    localparam logic [3:0] OP_PCS    = 4'hE;
    localparam logic [3:0] OP_HLT    = 4'hF;

    // Bit positions inside the 3-bit {Z,V,N} flag vector
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    // Halt sequencing FSM
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

endpackage

// File: rtl/ex_mem_flag_reg_flag_unit.sv
// ---------------------------------------------------------------------------
// ex_mem_flag_reg_flag_unit
//   Combinational next-flag logic. Given the opcode, ALU result and overflow
//   of the instruction in EX, returns the {Z,V,N} value the flag register
//   will hold after this cycle. When update is low the current flags pass
//   straight through, so the output is always "the flags after this edge".
// Ports
//   update     in   1       instruction is being accepted this cycle
//   opcode     in   OP_W    opcode in EX
//   result     in   DATA_W  ALU result
//   ovfl       in   1       ALU signed overflow
//   flags_cur  in   3       current registered flags
//   flags_nxt  out  3       flags after this cycle
// ---------------------------------------------------------------------------
module ex_mem_flag_reg_flag_unit
    import ex_mem_flag_reg_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int OP_W   = 4
) (
    input  logic              update,
    input  logic [OP_W-1:0]   opcode,
    input  logic [DATA_W-1:0] result,
    input  logic              ovfl,
    input  logic [2:0]        flags_cur,
    output logic [2:0]        flags_nxt
);

    always_comb begin
        flags_nxt = flags_cur;
        if (update) begin
            case (opcode)
                // Arithmetic sets all three flags.
                OP_ADD, OP_SUB: begin
                    flags_nxt[FLAG_Z] = (result == '0);
                    flags_nxt[FLAG_V] = ovfl;
                    flags_nxt[FLAG_N] = result[DATA_W-1];
                end
                // Logical ops and shifts only touch Z; V and N keep their value.
                OP_XOR, OP_SLL, OP_SRA, OP_ROR: begin
                    flags_nxt[FLAG_Z] = (result == '0);
                end
                // RED, PADDSB, memory and control opcodes leave flags alone.
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/ex_mem_flag_reg.sv
// ---------------------------------------------------------------------------
// ex_mem_flag_reg
//   EX->MEM pipeline register plus the architectural {Z,V,N} flag register
//   and the halt sequencer. One cycle of latency from EX to MEM.
//
// Optional build macro: FLAG_BYPASS_EN
//   Defined   : adds output flags_next[2:0], the combinational flag value
//               being written this cycle (held flags when no update), so the
//               branch unit can resolve without a 1-cycle flag hazard.
//   Undefined : no flags_next port; consumers read registered flags only.
//
// Ports
//   clk, rst      clock; synchronous active-high reset (beats everything)
//   ex_valid      EX holds a real instruction
//   ex_opcode     EX opcode
//   ex_result     ALU result (saturated for PADDSB)
//   ex_ovfl       ALU signed overflow
//   ex_rd         destination register
//   ex_wr_en      register write request
//   ex_st_data    SW store data
//   stall         hold all state
//   flush         kill the instruction entering MEM
//   mem_*         registered MEM-stage fields; mem_wr_en gated by valid
//   flags         {Z,V,N}
//   halted        sticky; set once HLT has drained past EX
//   dbg_state     halt FSM state (ST_RUN / ST_DRAIN / ST_HALTED)
//   flags_next    (FLAG_BYPASS_EN only) bypassed flag value
//
// Handshake: an EX instruction is taken on a rising edge when ex_valid is
// high, stall is low, flush is low and the FSM is in RUN. stall acts as the
// "not ready" back-pressure: while it is high nothing moves and the producer
// must keep its inputs stable. stall beats flush; hazard control re-presents
// the flush once the stall drops. mem_valid is the downstream valid and is
// only ever high for a taken instruction.
// ---------------------------------------------------------------------------
module ex_mem_flag_reg
    import ex_mem_flag_reg_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int OP_W   = 4,
    parameter int REG_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [OP_W-1:0]   ex_opcode,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              ex_ovfl,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic              ex_wr_en,
    input  logic [DATA_W-1:0] ex_st_data,
    input  logic              stall,
    input  logic              flush,
    output logic              mem_valid,
    output logic [OP_W-1:0]   mem_opcode,
    output logic [DATA_W-1:0] mem_result,
    output logic [REG_W-1:0]  mem_rd,
    output logic              mem_wr_en,
    output logic [DATA_W-1:0] mem_st_data,
    output logic [2:0]        flags,
    output logic              halted,
`ifdef FLAG_BYPASS_EN
    output logic [2:0]        flags_next,
`endif
    output logic [1:0]        dbg_state
);

    state_e     state_q;
    state_e     state_d;
    logic       halted_d;
    logic       acc;
    logic [2:0] flags_nxt;

    // Only RUN accepts; DRAIN and HALTED starve MEM and freeze the flags.
    assign acc = ex_valid & ~stall & ~flush & (state_q == ST_RUN);

    ex_mem_flag_reg_flag_unit #(
        .DATA_W (DATA_W),
        .OP_W   (OP_W)
    ) u_flag_unit (
        .update    (acc),
        .opcode    (ex_opcode),
        .result    (ex_result),
        .ovfl      (ex_ovfl),
        .flags_cur (flags),
        .flags_nxt (flags_nxt)
    );

`ifdef FLAG_BYPASS_EN
    assign flags_next = flags_nxt;
`endif

    assign dbg_state = state_q;

    // -----------------------------------------------------------------------
    // Halt FSM: next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        halted_d = halted;
        unique case (state_q)
            ST_RUN: begin
                // The HLT itself is accepted and travels into MEM.
                if (acc && (ex_opcode == OP_HLT)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!stall) begin
                    state_d  = ST_HALTED;
                    halted_d = 1'b1;
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State register, flags and halt flag
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            flags   <= 3'b000;
            halted  <= 1'b0;
        end else begin
            state_q <= state_d;
            halted  <= halted_d;
            // flags_nxt already equals flags whenever acc is low.
            flags   <= flags_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // EX->MEM pipeline register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_valid   <= 1'b0;
            mem_opcode  <= '0;
            mem_result  <= '0;
            mem_rd      <= '0;
            mem_wr_en   <= 1'b0;
            mem_st_data <= '0;
        end else if (stall) begin
            mem_valid   <= mem_valid;
        end else if (flush) begin
            // Data fields are don't-care behind an invalid slot; leave them.
            mem_valid   <= 1'b0;
            mem_wr_en   <= 1'b0;
        end else begin
            mem_valid   <= acc;
            mem_opcode  <= ex_opcode;
            mem_result  <= ex_result;
            mem_rd      <= ex_rd;
            mem_wr_en   <= acc & ex_wr_en;
            mem_st_data <= ex_st_data;
        end
    end

endmodule

// File: tb/tb_ex_mem_flag_reg.sv
module tb_ex_mem_flag_reg;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        ex_valid;
    logic [3:0]  ex_opcode;
    logic [15:0] ex_result;
    logic        ex_ovfl;
    logic [3:0]  ex_rd;
    logic        ex_wr_en;
    logic [15:0] ex_st_data;
    logic        stall;
    logic        flush;
    logic        mem_valid;
    logic [3:0]  mem_opcode;
    logic [15:0] mem_result;
    logic [3:0]  mem_rd;
    logic        mem_wr_en;
    logic [15:0] mem_st_data;
    logic [2:0]  flags;
    logic        halted;
    logic [1:0]  dbg_state;
`ifdef FLAG_BYPASS_EN
    logic [2:0]  flags_next;
`endif

    ex_mem_flag_reg dut (
        .clk         (clk),
        .rst         (rst),
        .ex_valid    (ex_valid),
        .ex_opcode   (ex_opcode),
        .ex_result   (ex_result),
        .ex_ovfl     (ex_ovfl),
        .ex_rd       (ex_rd),
        .ex_wr_en    (ex_wr_en),
        .ex_st_data  (ex_st_data),
        .stall       (stall),
        .flush       (flush),
        .mem_valid   (mem_valid),
        .mem_opcode  (mem_opcode),
        .mem_result  (mem_result),
        .mem_rd      (mem_rd),
        .mem_wr_en   (mem_wr_en),
        .mem_st_data (mem_st_data),
        .flags       (flags),
        .halted      (halted),
`ifdef FLAG_BYPASS_EN
        .flags_next  (flags_next),
`endif
        .dbg_state   (dbg_state)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- reference model ----------------
    // Machine mode: 0 = running, 1 = HLT sitting in MEM, 2 = halted.
    int          m_mode;
    logic        m_valid, m_wr_en, m_halted;
    logic [3:0]  m_op, m_rd;
    logic [15:0] m_res, m_st;
    logic [2:0]  m_flags;   // {Z,V,N}

    // Flags the architecture says result from the instruction now in EX.
    function automatic logic [2:0] model_flags_after();
        logic [2:0] f;
        bit take;
        f = m_flags;
        take = ex_valid && !stall && !flush && (m_mode == 0);
        if (take) begin
            if (ex_opcode == 4'h0 || ex_opcode == 4'h1)
                f = {ex_result == 16'h0, ex_ovfl, ex_result[15]};
            else if (ex_opcode inside {4'h2, 4'h4, 4'h5, 4'h6})
                f[2] = (ex_result == 16'h0);
        end
        return f;
    endfunction

    task automatic model_edge();
        bit take;
        if (rst) begin
            m_mode = 0; m_valid = 0; m_wr_en = 0; m_halted = 0;
            m_op = 0; m_rd = 0; m_res = 0; m_st = 0; m_flags = 0;
        end else if (!stall) begin
            take = ex_valid && !flush && (m_mode == 0);
            m_flags = model_flags_after();
            if (flush) begin
                m_valid = 0;
                m_wr_en = 0;
            end else begin
                m_valid = take;
                m_wr_en = take && ex_wr_en;
                m_op = ex_opcode; m_res = ex_result; m_rd = ex_rd; m_st = ex_st_data;
            end
            if (m_mode == 1) begin
                m_mode = 2;
                m_halted = 1;
            end else if (take && ex_opcode == 4'hF) begin
                m_mode = 1;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic r, input logic v, input logic [3:0] op,
                         input logic [15:0] res, input logic ov, input logic s,
                         input logic f);
        rst = r; ex_valid = v; ex_opcode = op; ex_result = res; ex_ovfl = ov;
        ex_rd = 4'($urandom_range(0, 15)); ex_wr_en = 1'($urandom_range(0, 1));
        ex_st_data = 16'($urandom_range(0, 65535));
        stall = s; flush = f;
    endtask

    // Advance one clock; the model follows the same edge; sample 1ns later.
    task automatic tick();
`ifdef FLAG_BYPASS_EN
        #2;
        n_checks++;
        if (flags_next !== model_flags_after())
            $display("FAIL flags_next: got %b expected %b", flags_next, model_flags_after());
        else n_pass++;
`endif
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        drive(1, 1, 4'h0, 16'h1234, 1, 0, 0);
        tick();
        tick();
        n_checks++;
        if ({mem_valid, mem_opcode, mem_result, mem_rd, mem_wr_en, mem_st_data} !== '0)
            $display("FAIL reset_mem: got v=%b op=%h res=%h rd=%h we=%b st=%h expected all 0",
                     mem_valid, mem_opcode, mem_result, mem_rd, mem_wr_en, mem_st_data);
        else n_pass++;
        n_checks++;
        if (flags !== 3'b000 || halted !== 1'b0)
            $display("FAIL reset_flags: got flags=%b halted=%b expected 000/0", flags, halted);
        else n_pass++;
    endtask

    task automatic test_flags();
        drive(0, 1, 4'h0, 16'h0000, 1, 0, 0);   // ADD, zero, overflow
        tick();
        n_checks++;
        if (flags !== 3'b110 || mem_valid !== 1'b1)
            $display("FAIL add_zero_ovfl: got flags=%b valid=%b expected 110/1", flags, mem_valid);
        else n_pass++;
        drive(0, 1, 4'h2, 16'h8001, 0, 0, 0);   // XOR: Z only
        tick();
        n_checks++;
        if (flags !== 3'b010)
            $display("FAIL xor_z_only: got %b expected 010", flags);
        else n_pass++;
        drive(0, 1, 4'h7, 16'h7878, 1, 0, 0);   // PADDSB: no flag change
        tick();
        n_checks++;
        if (flags !== 3'b010 || mem_opcode !== 4'h7 || mem_result !== 16'h7878)
            $display("FAIL paddsb_hold: got flags=%b op=%h res=%h expected 010/7/7878",
                     flags, mem_opcode, mem_result);
        else n_pass++;
        drive(0, 1, 4'h1, 16'hFFFF, 0, 0, 0);   // SUB negative
        tick();
        n_checks++;
        if (flags !== 3'b001)
            $display("FAIL sub_neg: got %b expected 001", flags);
        else n_pass++;
    endtask

    task automatic test_stall_flush();
        logic [15:0] res0;
        logic [3:0]  op0;
        res0 = mem_result;
        op0  = mem_opcode;
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 4'h0, 16'h0000, 1, 1, 1);
            tick();
            n_checks++;
            if (mem_valid !== 1'b1 || mem_result !== res0 || mem_opcode !== op0 || flags !== 3'b001)
                $display("FAIL stall_wins: cyc %0d got v=%b res=%h op=%h flags=%b expected 1/%h/%h/001",
                         i, mem_valid, mem_result, mem_opcode, flags, res0, op0);
            else n_pass++;
        end
        drive(0, 1, 4'h0, 16'h0000, 1, 0, 1);
        tick();
        n_checks++;
        if (mem_valid !== 1'b0 || mem_wr_en !== 1'b0 || flags !== 3'b001)
            $display("FAIL flush_only: got v=%b we=%b flags=%b expected 0/0/001",
                     mem_valid, mem_wr_en, flags);
        else n_pass++;
    endtask

    task automatic test_halt();
        drive(0, 1, 4'hF, 16'h0000, 0, 0, 0);
        tick();
        n_checks++;
        if (mem_opcode !== 4'hF || mem_valid !== 1'b1 || halted !== 1'b0)
            $display("FAIL hlt_enter: got op=%h v=%b halted=%b expected F/1/0",
                     mem_opcode, mem_valid, halted);
        else n_pass++;
        drive(0, 1, 4'h0, 16'h0000, 1, 0, 0);
        tick();
        n_checks++;
        if (halted !== 1'b1 || mem_valid !== 1'b0 || flags !== 3'b001)
            $display("FAIL hlt_drain: got halted=%b v=%b flags=%b expected 1/0/001",
                     halted, mem_valid, flags);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 4'h0, 16'h0000, 1, 0, 0);
            tick();
            n_checks++;
            if (mem_valid !== 1'b0 || flags !== 3'b001 || halted !== 1'b1)
                $display("FAIL halted_frozen: cyc %0d got v=%b flags=%b halted=%b expected 0/001/1",
                         i, mem_valid, flags, halted);
            else n_pass++;
        end
        drive(1, 0, 4'h0, 16'h0000, 0, 0, 0);
        tick();
        n_checks++;
        if (halted !== 1'b0 || flags !== 3'b000)
            $display("FAIL halt_reset: got halted=%b flags=%b expected 0/000", halted, flags);
        else n_pass++;
        drive(0, 1, 4'h0, 16'h8000, 0, 0, 0);
        tick();
        n_checks++;
        if (mem_valid !== 1'b1 || flags !== 3'b001)
            $display("FAIL run_after_reset: got v=%b flags=%b expected 1/001", mem_valid, flags);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [3:0] op;
        for (int i = 0; i < 600; i++) begin
            op = ($urandom_range(0, 39) == 0) ? 4'hF : 4'($urandom_range(0, 14));
            drive(($urandom_range(0, 79) == 0), ($urandom_range(0, 3) != 0), op,
                  ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom_range(0, 65535)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 5) == 0));
            tick();
            n_checks++;
            if (mem_valid !== m_valid || mem_wr_en !== m_wr_en || flags !== m_flags || halted !== m_halted)
                $display("FAIL rand_ctrl: cyc %0d got v=%b we=%b flags=%b halted=%b expected %b/%b/%b/%b",
                         i, mem_valid, mem_wr_en, flags, halted, m_valid, m_wr_en, m_flags, m_halted);
            else n_pass++;
            if (m_valid) begin
                n_checks++;
                if (mem_opcode !== m_op || mem_result !== m_res || mem_rd !== m_rd || mem_st_data !== m_st)
                    $display("FAIL rand_data: cyc %0d got op=%h res=%h rd=%h st=%h expected %h/%h/%h/%h",
                             i, mem_opcode, mem_result, mem_rd, mem_st_data, m_op, m_res, m_rd, m_st);
                else n_pass++;
            end
        end
    endtask

    initial begin
        drive(1, 0, 4'h0, 16'h0, 0, 0, 0);
        m_mode = 0; m_valid = 0; m_wr_en = 0; m_halted = 0;
        m_op = 0; m_rd = 0; m_res = 0; m_st = 0; m_flags = 0;
        @(negedge clk);
        test_reset();
        test_flags();
        test_stall_flush();
        test_halt();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
